// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, legality bound, sequencer states.
// CPU_SEQUENCER_SINGLE_STEP_EN adds the PAUSE state to the sequencer enum.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int OPC_W          = 4;

  localparam logic [OPC_W-1:0] OP_CLA  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_CMA  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_CMC  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ASL  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_STOP = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_STA  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_LDA  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_BAN  = 4'b1001;

  // Highest defined opcode; anything above it is illegal.
  localparam logic [OPC_W-1:0] OP_LAST = OP_BAN;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    ,
    ST_PAUSE = 3'd5
`endif
  } seq_state_e;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer (master) and its ROM / decoder / accumulator neighbours (slave).
interface cpu_sequencer_if #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W_DEFAULT,
  parameter int INSTR_W = 4 + ADDR_W
);

  // No valid/ready here: the contract is purely positional in time. imem_addr is
  // held through FETCH and LOAD, imem_rdata is valid the cycle after imem_addr,
  // dec_* are combinational from operate, and acc_we_o/ram_we_o are one-cycle
  // pulses that only ever occur in EXEC.
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         operate;
  logic [ADDR_W-1:0]  data_addr;
  logic               dec_stop;
  logic               dec_jmp;
  logic               dec_ban;
  logic               dec_acc_we;
  logic               dec_ram_we;
  logic               acc_neg;
  logic               acc_we_o;
  logic               ram_we_o;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output operate,
    output data_addr,
    input  dec_stop,
    input  dec_jmp,
    input  dec_ban,
    input  dec_acc_we,
    input  dec_ram_we,
    input  acc_neg,
    output acc_we_o,
    output ram_we_o
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  operate,
    input  data_addr,
    output dec_stop,
    output dec_jmp,
    output dec_ban,
    output dec_acc_we,
    output dec_ram_we,
    output acc_neg,
    input  acc_we_o,
    input  ram_we_o
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/load/execute sequencer: owns PC and IR, gates decoder write strobes, resolves JMP/BAN/STOP.
// CPU_SEQUENCER_SINGLE_STEP_EN adds the step input and a PAUSE state after each non-STOP EXEC.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = 4 + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  input  logic              step,
`endif
  cpu_sequencer_if.master   bus,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output seq_state_e        state_o
);

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO = '0;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  localparam seq_state_e ST_AFTER_EXEC = ST_PAUSE;
`else
  localparam seq_state_e ST_AFTER_EXEC = ST_FETCH;
`endif

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  target;
  logic               legal;
  logic               in_exec;

  assign opcode  = ir_q[INSTR_W-1 -: 4];
  assign target  = ir_q[ADDR_W-1:0];
  assign legal   = op_legal(opcode);
  assign in_exec = (state_q == ST_EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_ZERO;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ir_d    = bus.imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // An illegal opcode ignores every decoder output, STOP included.
        if (!legal) begin
          pc_d      = pc_q + PC_ONE;
          illegal_d = 1'b1;
          state_d   = ST_AFTER_EXEC;
        end else if (bus.dec_stop) begin
          state_d = ST_HALT;
        end else begin
          if (bus.dec_jmp || (bus.dec_ban && bus.acc_neg)) pc_d = target;
          else                                             pc_d = pc_q + PC_ONE;
          state_d = ST_AFTER_EXEC;
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_d      = PC_ZERO;
          illegal_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step || start) state_d = ST_FETCH;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.operate   = opcode;
  assign bus.data_addr = target;

  // Combinational from state_q so an async reset kills a strobe mid-cycle.
  assign bus.acc_we_o  = in_exec && legal && bus.dec_acc_we;
  assign bus.ram_we_o  = in_exec && legal && bus.dec_ram_we;

  assign busy    = (state_q == ST_FETCH) || (state_q == ST_LOAD) || in_exec;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule
